// File: rtl/jelly_rtos_pkg.sv
// Shared types for the RTOS wait queue: slot payload, slot source select, error codes.
// Slot fields are sized to the widest supported ID/priority; narrower configurations zero-pad.
package jelly_rtos_pkg;

  localparam int unsigned QUE_ID_MAX  = 8;
  localparam int unsigned QUE_PRI_MAX = 8;

  typedef struct packed {
    logic                   valid;
    logic [QUE_ID_MAX-1:0]  id;
    logic [QUE_PRI_MAX-1:0] pri;
  } que_entry_t;

  typedef enum logic [1:0] {
    SLOT_HOLD,
    SLOT_ABOVE,
    SLOT_BELOW,
    SLOT_NEW
  } slot_sel_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_DUP  = 2'd1;
  localparam logic [1:0] ERR_FULL = 2'd2;
  localparam logic [1:0] ERR_MISS = 2'd3;

endpackage

// File: rtl/jelly_rtos_wait_queue_if.sv
// Request/status bundle between kernel objects (master) and the wait queue (slave).
interface jelly_rtos_wait_queue_if #(
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned PRI_WIDTH   = 4,
  parameter int unsigned COUNT_WIDTH = 5
);

  logic                   order_pri;
  logic [ID_WIDTH-1:0]    add_id;
  logic [PRI_WIDTH-1:0]   add_pri;
  logic                   add_valid;
  logic [ID_WIDTH-1:0]    remove_id;
  logic                   remove_valid;
  logic [ID_WIDTH-1:0]    chg_id;
  logic [PRI_WIDTH-1:0]   chg_pri;
  logic                   chg_valid;
  logic [ID_WIDTH-1:0]    top_id;
  logic [PRI_WIDTH-1:0]   top_pri;
  logic                   top_valid;
  logic [COUNT_WIDTH-1:0] count;
  logic                   full;
  logic                   add_error;
  logic                   remove_error;

  modport master (
    output order_pri, add_id, add_pri, add_valid, remove_id, remove_valid,
           chg_id, chg_pri, chg_valid,
    input  top_id, top_pri, top_valid, count, full, add_error, remove_error
  );

  modport slave (
    input  order_pri, add_id, add_pri, add_valid, remove_id, remove_valid,
           chg_id, chg_pri, chg_valid,
    output top_id, top_pri, top_valid, count, full, add_error, remove_error
  );

endinterface

// File: rtl/jelly_rtos_wait_queue_slot.sv
// One wait-queue slot: holds, shifts from a neighbour, or loads the new entry.
module jelly_rtos_wait_queue_slot
  import jelly_rtos_pkg::*;
(
  input  logic       reset,
  input  logic       clk,
  input  logic       cke,
  input  logic       i_ins_here,
  input  logic       i_ins_after,
  input  logic       i_rem_at_after,
  input  logic       i_rem_after,
  input  que_entry_t i_above,
  input  que_entry_t i_below,
  input  que_entry_t i_new,
  output que_entry_t o_entry
);

  slot_sel_e  w_sel;
  que_entry_t r_entry;

  // Removal is applied first, then insertion on the compacted array.
  always_comb begin
    w_sel = SLOT_HOLD;
    if (i_ins_here) begin
      w_sel = SLOT_NEW;
    end else if (!i_ins_after) begin
      w_sel = i_rem_at_after ? SLOT_BELOW : SLOT_HOLD;
    end else begin
      w_sel = i_rem_after ? SLOT_HOLD : SLOT_ABOVE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_entry <= '0;
    end else if (cke) begin
      case (w_sel)
        SLOT_ABOVE: r_entry <= i_above;
        SLOT_BELOW: r_entry <= i_below;
        SLOT_NEW:   r_entry <= i_new;
        default:    r_entry <= r_entry;
      endcase
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/jelly_rtos_wait_queue.sv
// Sorted hardware wait queue (priority or FIFO order), head read by the scheduler.
// Optional in-place priority change enabled by JELLY_RTOS_WAIT_QUEUE_CHGPRI_EN.
module jelly_rtos_wait_queue
  import jelly_rtos_pkg::*;
#(
  parameter int unsigned QUE_SIZE    = 16,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned PRI_WIDTH   = 4,
  parameter int unsigned COUNT_WIDTH = $clog2(QUE_SIZE + 1)
)
(
  input  logic reset,
  input  logic clk,
  input  logic cke,
  jelly_rtos_wait_queue_if.slave bus
);

  localparam int unsigned POS_WIDTH = $clog2(QUE_SIZE + 1);

  que_entry_t             w_slot  [QUE_SIZE];
  que_entry_t             w_above [QUE_SIZE];
  que_entry_t             w_below [QUE_SIZE];
  que_entry_t             w_a1    [QUE_SIZE];
  que_entry_t             w_new;
  logic [QUE_SIZE-1:0]    w_match;
  logic [QUE_SIZE-1:0]    w_ins_here;
  logic [QUE_SIZE-1:0]    w_ins_after;
  logic [QUE_SIZE-1:0]    w_rem_at_after;
  logic [QUE_SIZE-1:0]    w_rem_after;
  logic                   w_rem_v;
  logic                   w_add_v;
  logic                   w_mode_pri;
  logic                   w_chg;
  logic [ID_WIDTH-1:0]    w_rem_id;
  logic [ID_WIDTH-1:0]    w_add_id;
  logic [PRI_WIDTH-1:0]   w_add_pri;
  logic                   w_found;
  logic                   w_dup;
  logic                   w_full1;
  logic                   w_add_ok;
  logic [POS_WIDTH-1:0]   w_rem_pos;
  logic [POS_WIDTH-1:0]   w_stop_pos;
  logic [POS_WIDTH-1:0]   w_ins_pos;
  logic [1:0]             w_add_err;
  logic [1:0]             w_rem_err;
  logic [COUNT_WIDTH-1:0] w_cnt_next;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_full;
  logic                   r_add_error;
  logic                   r_remove_error;

  // A change request becomes a remove of chg_id plus a re-add with the new priority.
  always_comb begin
    w_rem_v    = bus.remove_valid;
    w_rem_id   = bus.remove_id;
    w_add_v    = bus.add_valid;
    w_add_id   = bus.add_id;
    w_add_pri  = bus.add_pri;
    w_mode_pri = bus.order_pri;
    w_chg      = 1'b0;
`ifdef JELLY_RTOS_WAIT_QUEUE_CHGPRI_EN
    if (bus.chg_valid) begin
      w_chg     = 1'b1;
      w_rem_v   = 1'b1;
      w_rem_id  = bus.chg_id;
      w_add_v   = 1'b1;
      w_add_id  = bus.chg_id;
      w_add_pri = bus.chg_pri;
    end
`endif
  end

`ifndef JELLY_RTOS_WAIT_QUEUE_CHGPRI_EN
  logic w_unused_chg;
  assign w_unused_chg = ^{bus.chg_valid, bus.chg_id, bus.chg_pri};
`endif

  always_comb begin
    w_new.valid = 1'b1;
    w_new.id    = QUE_ID_MAX'(w_add_id);
    w_new.pri   = QUE_PRI_MAX'(w_add_pri);
  end

  always_comb begin
    w_match   = '0;
    w_rem_pos = POS_WIDTH'(QUE_SIZE);
    for (int i = QUE_SIZE - 1; i >= 0; i--) begin
      w_match[i] = w_rem_v && w_slot[i].valid && (w_slot[i].id == QUE_ID_MAX'(w_rem_id));
      if (w_match[i]) w_rem_pos = POS_WIDTH'(i);
    end
    w_found = |w_match;

    // Array as it looks after the remove; insert position and checks use this view.
    for (int i = 0; i < QUE_SIZE; i++) begin
      w_a1[i] = (w_found && (POS_WIDTH'(i) >= w_rem_pos)) ? w_below[i] : w_slot[i];
    end

    w_dup      = 1'b0;
    w_stop_pos = POS_WIDTH'(QUE_SIZE);
    for (int i = QUE_SIZE - 1; i >= 0; i--) begin
      if (w_a1[i].valid && (w_a1[i].id == QUE_ID_MAX'(w_add_id))) w_dup = 1'b1;
      if (!w_a1[i].valid || (w_mode_pri && (w_a1[i].pri > QUE_PRI_MAX'(w_add_pri))))
        w_stop_pos = POS_WIDTH'(i);
    end
    w_full1  = w_a1[QUE_SIZE-1].valid;
    w_add_ok = w_add_v && !w_dup && !w_full1 && (!w_chg || w_found);

    // FIFO-mode change re-inserts at the old position, i.e. updates in place.
    w_ins_pos = POS_WIDTH'(QUE_SIZE);
    if (w_add_ok) w_ins_pos = (w_chg && !w_mode_pri) ? w_rem_pos : w_stop_pos;

    for (int i = 0; i < QUE_SIZE; i++) begin
      w_ins_here[i]     = (w_ins_pos == POS_WIDTH'(i));
      w_ins_after[i]    = (POS_WIDTH'(i) > w_ins_pos);
      w_rem_at_after[i] = (POS_WIDTH'(i) >= w_rem_pos);
      w_rem_after[i]    = (POS_WIDTH'(i) > w_rem_pos);
    end

    w_add_err = ERR_NONE;
    if (w_add_v && !w_chg) begin
      if (w_dup)        w_add_err = ERR_DUP;
      else if (w_full1) w_add_err = ERR_FULL;
    end
    w_rem_err = (w_rem_v && !w_found) ? ERR_MISS : ERR_NONE;
  end

  always_comb begin
    w_cnt_next = r_count;
    if (w_found && !w_add_ok) begin
      if (r_count != '0) w_cnt_next = r_count - COUNT_WIDTH'(1);
    end else if (w_add_ok && !w_found) begin
      if (r_count != COUNT_WIDTH'(QUE_SIZE)) w_cnt_next = r_count + COUNT_WIDTH'(1);
    end
  end

  for (genvar gi = 0; gi < QUE_SIZE; gi++) begin : g_slot
    if (gi == 0) begin : g_head
      assign w_above[gi] = '0;
    end else begin : g_mid
      assign w_above[gi] = w_slot[gi-1];
    end
    if (gi == QUE_SIZE - 1) begin : g_tail
      assign w_below[gi] = '0;
    end else begin : g_body
      assign w_below[gi] = w_slot[gi+1];
    end

    jelly_rtos_wait_queue_slot u_slot (
      .reset          (reset),
      .clk            (clk),
      .cke            (cke),
      .i_ins_here     (w_ins_here[gi]),
      .i_ins_after    (w_ins_after[gi]),
      .i_rem_at_after (w_rem_at_after[gi]),
      .i_rem_after    (w_rem_after[gi]),
      .i_above        (w_above[gi]),
      .i_below        (w_below[gi]),
      .i_new          (w_new),
      .o_entry        (w_slot[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count        <= '0;
      r_full         <= 1'b0;
      r_add_error    <= 1'b0;
      r_remove_error <= 1'b0;
    end else if (cke) begin
      r_count        <= w_cnt_next;
      r_full         <= (w_cnt_next == COUNT_WIDTH'(QUE_SIZE));
      r_add_error    <= (w_add_err != ERR_NONE);
      r_remove_error <= (w_rem_err != ERR_NONE);
    end
  end

  assign bus.top_valid    = w_slot[0].valid;
  assign bus.top_id       = w_slot[0].valid ? ID_WIDTH'(w_slot[0].id)   : '0;
  assign bus.top_pri      = w_slot[0].valid ? PRI_WIDTH'(w_slot[0].pri) : '0;
  assign bus.count        = r_count;
  assign bus.full         = r_full;
  assign bus.add_error    = r_add_error;
  assign bus.remove_error = r_remove_error;

endmodule

// File: tb/tb_jelly_rtos_wait_queue.sv
// Table-driven bench for jelly_rtos_wait_queue (QUE_SIZE = 4) with an expected-result queue.
module tb_jelly_rtos_wait_queue;

  localparam int unsigned QS  = 4;
  localparam int unsigned IDW = 4;
  localparam int unsigned PRW = 4;
  localparam int unsigned CW  = 3;

  logic clk = 1'b0;
  logic rst;
  logic cke;

  jelly_rtos_wait_queue_if #(.ID_WIDTH(IDW), .PRI_WIDTH(PRW), .COUNT_WIDTH(CW)) bus ();

  jelly_rtos_wait_queue #(
    .QUE_SIZE(QS), .ID_WIDTH(IDW), .PRI_WIDTH(PRW), .COUNT_WIDTH(CW)
  ) dut (
    .reset (rst),
    .clk   (clk),
    .cke   (cke),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  rst, cke, mode, av;
    int    aid, apri;
    logic  rv;
    int    rid;
    logic  cv;
    int    cid, cpri;
    int    e_tid, e_tpri;
    logic  e_tv;
    int    e_cnt;
    logic  e_full, e_aerr, e_rerr;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic v(input string nm, input logic r, input logic ck, input logic m,
                   input logic av, input int aid, input int apri,
                   input logic rv, input int rid,
                   input int tid, input int tpri, input logic tv, input int cnt,
                   input logic fl, input logic ae, input logic re,
                   input logic cv = 1'b0, input int cid = 0, input int cpri = 0);
    vec_t t;
    t.name = nm; t.rst = r; t.cke = ck; t.mode = m;
    t.av = av; t.aid = aid; t.apri = apri; t.rv = rv; t.rid = rid;
    t.cv = cv; t.cid = cid; t.cpri = cpri;
    t.e_tid = tid; t.e_tpri = tpri; t.e_tv = tv; t.e_cnt = cnt;
    t.e_full = fl; t.e_aerr = ae; t.e_rerr = re;
    vecs.push_back(t);
  endtask

  task automatic apply(input vec_t t);
    vec_t e;
    rst              = t.rst;
    cke              = t.cke;
    bus.order_pri    = t.mode;
    bus.add_valid    = t.av;
    bus.add_id       = IDW'(t.aid);
    bus.add_pri      = PRW'(t.apri);
    bus.remove_valid = t.rv;
    bus.remove_id    = IDW'(t.rid);
    bus.chg_valid    = t.cv;
    bus.chg_id       = IDW'(t.cid);
    bus.chg_pri      = PRW'(t.cpri);
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.name, "/top_id"},    32'(bus.top_id),       32'(e.e_tid));
    chk({e.name, "/top_pri"},   32'(bus.top_pri),      32'(e.e_tpri));
    chk({e.name, "/top_valid"}, 32'(bus.top_valid),    32'(e.e_tv));
    chk({e.name, "/count"},     32'(bus.count),        32'(e.e_cnt));
    chk({e.name, "/full"},      32'(bus.full),         32'(e.e_full));
    chk({e.name, "/add_err"},   32'(bus.add_error),    32'(e.e_aerr));
    chk({e.name, "/rem_err"},   32'(bus.remove_error), 32'(e.e_rerr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cke = 1'b1;
    bus.order_pri = 1'b0; bus.add_valid = 1'b0; bus.add_id = '0; bus.add_pri = '0;
    bus.remove_valid = 1'b0; bus.remove_id = '0;
    bus.chg_valid = 1'b0; bus.chg_id = '0; bus.chg_pri = '0;

    //  name          r ck m  av id pr  rv id   tid tpr tv cnt fl ae re
    v("rst",          1,1,0, 0,0,0,  0,0,  0,0,0,0, 0,0,0);
    v("p_add3",       0,1,1, 1,3,5,  0,0,  3,5,1,1, 0,0,0);
    v("p_add7",       0,1,1, 1,7,2,  0,0,  7,2,1,2, 0,0,0);
    v("p_add9",       0,1,1, 1,9,5,  0,0,  7,2,1,3, 0,0,0);
    v("p_rm7",        0,1,1, 0,0,0,  1,7,  3,5,1,2, 0,0,0);
    v("p_rm3",        0,1,1, 0,0,0,  1,3,  9,5,1,1, 0,0,0);
    v("p_rm9",        0,1,1, 0,0,0,  1,9,  0,0,0,0, 0,0,0);
    v("f_add1",       0,1,0, 1,1,8,  0,0,  1,8,1,1, 0,0,0);
    v("f_add2",       0,1,0, 1,2,0,  0,0,  1,8,1,2, 0,0,0);
    v("f_add3",       0,1,0, 1,3,4,  0,0,  1,8,1,3, 0,0,0);
    v("f_rm2",        0,1,0, 0,0,0,  1,2,  1,8,1,2, 0,0,0);
    v("f_rm1",        0,1,0, 0,0,0,  1,1,  3,4,1,1, 0,0,0);
    v("f_rm3",        0,1,0, 0,0,0,  1,3,  0,0,0,0, 0,0,0);
    v("fl_add0",      0,1,0, 1,0,1,  0,0,  0,1,1,1, 0,0,0);
    v("fl_add1",      0,1,0, 1,1,1,  0,0,  0,1,1,2, 0,0,0);
    v("fl_add2",      0,1,0, 1,2,1,  0,0,  0,1,1,3, 0,0,0);
    v("fl_add3",      0,1,0, 1,3,1,  0,0,  0,1,1,4, 1,0,0);
    v("fl_ovf",       0,1,0, 1,5,0,  0,0,  0,1,1,4, 1,1,0);
    v("fl_swap",      0,1,1, 1,5,0,  1,0,  5,0,1,4, 1,0,0);
    v("d_miss",       0,1,1, 0,0,0,  1,6,  5,0,1,4, 1,0,1);
    v("d_rm3",        0,1,1, 0,0,0,  1,3,  5,0,1,3, 0,0,0);
    v("d_dup",        0,1,1, 1,2,7,  0,0,  5,0,1,3, 0,1,0);
    v("d_idle",       0,1,1, 0,0,0,  0,0,  5,0,1,3, 0,0,0);
    v("d_requeue",    0,1,1, 1,5,9,  1,5,  1,1,1,3, 0,0,0);
    v("c_miss",       0,1,1, 0,0,0,  1,6,  1,1,1,3, 0,0,1);
    v("c_hold",       0,0,1, 1,8,0,  1,1,  1,1,1,3, 0,0,1);
    v("c_release",    0,1,1, 0,0,0,  0,0,  1,1,1,3, 0,0,0);
    v("c_rm1",        0,1,1, 0,0,0,  1,1,  2,1,1,2, 0,0,0);
    v("c_add8",       0,1,0, 1,8,0,  0,0,  2,1,1,3, 0,0,0);
    v("rs_assert",    1,1,1, 1,9,0,  0,0,  0,0,0,0, 0,0,0);
    v("rs_after",     0,1,1, 0,0,0,  0,0,  0,0,0,0, 0,0,0);
    v("e_miss",       0,1,1, 0,0,0,  1,1,  0,0,0,0, 0,0,1);
    v("e_idle",       0,1,1, 0,0,0,  0,0,  0,0,0,0, 0,0,0);
`ifdef JELLY_RTOS_WAIT_QUEUE_CHGPRI_EN
    v("ch_add4",      0,1,1, 1,4,1,  0,0,  4,1,1,1, 0,0,0);
    v("ch_add5",      0,1,1, 1,5,3,  0,0,  4,1,1,2, 0,0,0);
    v("ch_add6",      0,1,1, 1,6,3,  0,0,  4,1,1,3, 0,0,0);
    v("ch_cke0",      0,0,1, 0,0,0,  0,0,  4,1,1,3, 0,0,0, 1,4,3);
    v("ch_chg4",      0,1,1, 0,0,0,  0,0,  5,3,1,3, 0,0,0, 1,4,3);
    v("ch_rm5",       0,1,1, 0,0,0,  1,5,  6,3,1,2, 0,0,0);
    v("ch_rm6",       0,1,1, 0,0,0,  1,6,  4,3,1,1, 0,0,0);
    v("ch_miss",      0,1,1, 0,0,0,  0,0,  4,3,1,1, 0,0,1, 1,9,0);
    v("ch_fifo_add",  0,1,0, 1,1,5,  0,0,  4,3,1,2, 0,0,0);
    v("ch_fifo_chg",  0,1,0, 0,0,0,  0,0,  4,9,1,2, 0,0,0, 1,4,9);
    v("ch_over",      0,1,1, 1,7,0,  1,4,  1,0,1,2, 0,0,0, 1,1,0);
    v("ch_rm1",       0,1,1, 0,0,0,  1,1,  4,9,1,1, 0,0,0);
    v("ch_rm4",       0,1,1, 0,0,0,  1,4,  0,0,0,0, 0,0,0);
`else
    v("nc_add",       0,1,1, 1,4,1,  0,0,  4,1,1,1, 0,0,0, 1,4,9);
    v("nc_chg",       0,1,1, 0,0,0,  0,0,  4,1,1,1, 0,0,0, 1,4,0);
    v("nc_chgmiss",   0,1,1, 0,0,0,  0,0,  4,1,1,1, 0,0,0, 1,9,0);
    v("nc_rm",        0,1,1, 0,0,0,  1,4,  0,0,0,0, 0,0,0, 1,7,0);
`endif

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Each new add outranks the previous head; then overflow with a missing remove, then drain.
    vecs.delete();
    for (int k = 0; k < 4; k++)
      v($sformatf("s_fill%0d", k), 0,1,1, 1,10+k,3-k, 0,0, 10+k,3-k,1,k+1, (k == 3),0,0);
    v("s_ovf_miss",   0,1,1, 1,1,0,  1,6,  13,0,1,4, 1,1,1);
    for (int k = 0; k < 3; k++)
      v($sformatf("s_drain%0d", k), 0,1,1, 0,0,0, 1,13-k, 12-k,k+1,1,3-k, 0,0,0);
    v("s_drain3",     0,1,1, 0,0,0,  1,10, 0,0,0,0, 0,0,0);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jelly_rtos_wait_queue.md
# jelly_rtos_wait_queue

Hardware wait queue for the RTOS kernel core. It holds up to QUE_SIZE task IDs, ordered either by priority or by arrival, with the ordering mode selectable at run time. It supports add, remove-by-ID and an optional in-place priority change, and reports duplicate-add, overflow and remove-miss errors. It sits between the semaphore, event-flag and mailbox objects and the scheduler, which reads the queue head each cycle.

## Interface

Parameters:
- QUE_SIZE, 16: number of entries, minimum 2.
- ID_WIDTH, 4: task ID width.
- PRI_WIDTH, 4: priority width; a smaller value means a higher priority.
- COUNT_WIDTH, $clog2(QUE_SIZE+1): width of `count`.

Ports (one clock; reset is synchronous and active-high):
- reset  in  1  synchronous, active-high reset.
- clk  in  1  clock; all state updates on its rising edge.
- cke  in  1  clock enable; when low, all state and outputs hold.
- order_pri  in  1  1 = priority order, 0 = FIFO order; sampled per add.
- add_id  in  ID_WIDTH  ID to enqueue.
- add_pri  in  PRI_WIDTH  priority of `add_id`.
- add_valid  in  1  add request, single cycle.
- remove_id  in  ID_WIDTH  ID to dequeue.
- remove_valid  in  1  remove request, single cycle.
- chg_id  in  ID_WIDTH  ID whose priority changes (only with JELLY_RTOS_WAIT_QUEUE_CHGPRI_EN).
- chg_pri  in  PRI_WIDTH  new priority (only with the macro).
- chg_valid  in  1  change request (only with the macro).
- top_id  out  ID_WIDTH  head entry ID.
- top_pri  out  PRI_WIDTH  head entry priority.
- top_valid  out  1  queue is non-empty.
- count  out  COUNT_WIDTH  number of valid entries.
- full  out  1  count == QUE_SIZE.
- add_error  out  1  one-cycle pulse: the add was dropped (duplicate ID or full).
- remove_error  out  1  one-cycle pulse: the remove ID was not present.

## Operation

- Storage is a sorted array of slots `{valid, id, pri}`; slot 0 is the head. Valid slots are always contiguous from slot 0.
- Remove: the matching slot is invalidated and all slots below it shift up one place. If no slot matches, `remove_error` pulses and the array is unchanged.
- Add in priority mode: the entry is inserted before the first valid slot whose priority is numerically greater than `add_pri`, so equal priorities stay in FIFO order. Slots from that point shift down one place.
- Add in FIFO mode: the entry is appended at slot `count`.
- Add is dropped and `add_error` pulses in either of these cases:
  - `add_id` is already present and is not being removed in the same cycle;
  - the queue is full and no remove succeeds in the same cycle.
- Simultaneous add and remove in one cycle: the remove is applied first, then the add is applied to the result. A full queue with a valid remove therefore accepts the add. Adding and removing the same ID in one cycle re-queues that ID at its new position.
- Priority change (`chg_valid`) is an atomic remove of `chg_id` followed by an add of `chg_id` with `chg_pri` in priority mode. The entry goes behind existing entries of equal priority.
  - In FIFO mode only the stored priority updates; the position is unchanged.
  - A change for an absent ID pulses `remove_error`.
  - `chg_valid` has priority over `add_valid` and `remove_valid`; when it is high, both of those are ignored that cycle.
- Changing `order_pri` never reorders existing entries; it affects only later inserts.
- `count` is computed with saturating arithmetic; it never exceeds QUE_SIZE and never goes below 0.

## Timing

- Every request is registered: its effect appears on `top_*`, `count`, `full` and the error pulses on the cycle after the `clk` edge where it was sampled with `cke` = 1. Latency is 1 cycle.
- Throughput is one operation set per cycle with no back-pressure.
- `top_*`, `count` and `full` are registered outputs with no combinational path from the inputs.
- Reset values: all slots invalid; `top_id` = 0, `top_pri` = 0, `top_valid` = 0, `count` = 0, `full` = 0, `add_error` = 0, `remove_error` = 0.
- Reset has priority over `cke` and clears the queue even mid-operation. Requests sampled in a reset cycle are discarded.
- When `top_valid` = 0, `top_id` and `top_pri` read as 0.

## Configuration

- JELLY_RTOS_WAIT_QUEUE_CHGPRI_EN defined: the `chg_*` ports and the priority-change path are present.
- Macro not defined: the `chg_*` ports remain in the port list but are ignored, and no change logic is synthesized. The block then behaves as add/remove only.

## Structure

- Package `jelly_rtos_pkg`: the `que_entry_t` struct typedef (`valid`, `id`, `pri`) and the error-code localparams.
- Sub-module `jelly_rtos_wait_queue_slot`: a single slot register. It selects among hold, take-from-above, take-from-below and load-new, based on per-slot insert and remove position vectors computed in the parent.
- The parent computes the match vector, insert position and shift controls; it instantiates QUE_SIZE slots in a generate loop.

## Test plan

- Priority mode: add IDs 3/pri 5, 7/pri 2, 9/pri 5 on consecutive cycles -> head order 7, 3, 9; `count` = 3; `top_pri` = 2 one cycle after the second add.
- FIFO mode: add IDs 1/pri 8, 2/pri 0, 3/pri 4 -> head order 1, 2, 3; remove 2 -> order 1, 3; `count` = 2.
- QUE_SIZE = 4, fill with IDs 0–3, add ID 5 -> `add_error` pulses and `full` stays 1. Then add 5 and remove 0 in the same cycle -> no error, `count` = 4, ID 5 present.
- Remove an absent ID 6 -> `remove_error` pulses for 1 cycle and the queue is unchanged. Add an ID that is already present -> `add_error` pulses and the queue is unchanged.
- With the macro defined, queue 4/pri 1, 5/pri 3, 6/pri 3; change 4 to pri 3 -> order 5, 6, 4. With `cke` = 0 the same stimulus produces no change.
- Assert `reset` while `count` = 3 and an add is pending -> next cycle `count` = 0, `top_valid` = 0, no error pulses.
